conv_mem_responder: RTL and testbench
=====================================

Name: conv_mem_responder

Overview:
- Memory-side responder for the convolution engine's image/layer-memory interface.
- Holds the 64x64 input image (host-loaded), answers the engine's image reads (iaddr/idata), and accepts layer writes and read-backs (cwr/crd/csel).
- Raises ready, tracks busy, then exposes results for host dump.
- Sits between the host/loader and the engine, replacing behavioural memory models in synthesizable system builds.

Parameters:
- ADDR_W, 12, address width of all banks
- DATA_W, 20, data word width
- L1_DEPTH, 1024, depth of layer-1 (max-pool) bank
- TIMEOUT, 1048576, SERVE cycles allowed before busy must fall

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- host_wr  in  1  image load strobe (LOAD state only)
- host_addr  in  ADDR_W  image load / dump address
- host_data  in  DATA_W  image load data
- host_start  in  1  end load, arm engine
- host_rd  in  1  dump read strobe (DONE state only)
- host_rd_sel  in  1  dump bank: 0=L0, 1=L1
- host_rd_data  out  DATA_W  dump data, registered
- host_rd_valid  out  1  dump data valid
- done  out  1  one-cycle pulse on busy fall
- timeout  out  1  sticky, TIMEOUT exceeded
- ready  out  1  to engine
- busy  in  1  from engine
- iaddr  in  ADDR_W  image read address
- idata  out  DATA_W  image read data, combinational
- cwr  in  1  layer write enable
- caddr_wr  in  ADDR_W  layer write address
- cdata_wr  in  DATA_W  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  ADDR_W  layer read address
- cdata_rd  out  DATA_W  layer read data, combinational
- csel  in  3  bank select

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ready=0, done=0, timeout=0, host_rd_valid=0, host_rd_data=0, cdata_rd=0 when not crd. Memory arrays not cleared; reset mid-operation aborts to IDLE immediately, and already-written contents persist.
- Banks: IMG 4096xDATA_W; L0 4096xDATA_W (csel=3'b001); L1 L1_DEPTHxDATA_W (csel=3'b011). Any other csel: write dropped, read returns 0.
- idata = IMG[iaddr], zero-latency combinational, valid in every state. The engine captures it on the edge after driving iaddr.
- cdata_rd = crd ? bank[csel][caddr_rd] : 0, combinational.
- L1 address >= L1_DEPTH: write dropped, read returns 0.
- Writes commit on the rising edge when cwr=1, in SERVE only; ignored elsewhere.
- Same-cycle cwr and crd to the same bank/address: cdata_rd shows the old value; new value visible the next cycle.
- FSM states:
  - IDLE -> LOAD on the first cycle after reset.
  - LOAD: host_wr writes IMG[host_addr]. host_start -> ARM; host_wr in the same cycle as host_start is still committed.
  - ARM: ready=1; ready held until busy=1 is sampled, then ready=0 -> SERVE. Registered: ready drops one cycle after busy first seen high.
  - SERVE: cycle counter counts from 0. busy 1->0 (previous sample 1, current 0) -> DONE with done=1 for exactly one cycle. Counter reaching TIMEOUT -> timeout=1 (sticky until reset), -> DONE, no done pulse.
  - DONE: host_rd reads bank host_rd_sel at host_addr; host_rd_data/host_rd_valid appear 1 cycle later. host_rd_valid is 0 when no read. host_start -> LOAD (new image, same banks).
- host_wr/host_rd outside their states are ignored. busy falling outside SERVE is ignored.

Optional Feature:
- Macro: CONV_MEM_STATS_EN.
- Defined: adds outputs wr_cnt_l0 (13b), wr_cnt_l1 (11b), err_cnt (8b, saturating).
  - wr_cnt_l0/wr_cnt_l1 count committed writes per bank, cleared on ARM entry.
  - err_cnt counts cwr/crd with an illegal csel or an out-of-range L1 address, during SERVE.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Load IMG[0]=20'h00010, IMG[4095]=20'hFFFFF, host_start -> idata shows both values combinationally; ready=1 until busy high, ready=0 the cycle after.
- SERVE, cwr=1, csel=001, caddr_wr=5, cdata_wr=20'h12345; next cycle crd=1, caddr_rd=5 -> cdata_rd=20'h12345.
- Same cycle: cwr to L1 addr 7 data 20'hAAAAA and crd at L1 addr 7 (old value 0) -> cdata_rd=0 that cycle, 20'hAAAAA the next.
- csel=3'b010 write, then L1 write at addr 1024 -> no bank change; reads return 0; err_cnt=2 with CONV_MEM_STATS_EN.
- busy falls -> done high exactly 1 cycle; DONE, host_rd sel=0 addr=5 -> host_rd_data=20'h12345, host_rd_valid=1 one cycle later.
- TIMEOUT=16, busy held high -> timeout=1 after 16 SERVE cycles, no done. Reset asserted mid-SERVE -> IDLE next cycle, ready=0, L0[5] still 20'h12345 after reload and dump.

Source files
------------

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the convolution engine: image bank, two layer banks, host load/dump FSM.
// Define CONV_MEM_STATS_EN to add the write/error statistics outputs.
module conv_mem_responder #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned DATA_W   = 20,
   parameter int unsigned L1_DEPTH = 1024,
   parameter int unsigned TIMEOUT  = 1048576
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_wr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   input  logic              host_start,
   input  logic              host_rd,
   input  logic              host_rd_sel,
   output logic [DATA_W-1:0] host_rd_data,
   output logic              host_rd_valid,
   output logic              done,
   output logic              timeout,
   output logic              ready,
   input  logic              busy,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] idata,
   input  logic              cwr,
   input  logic [ADDR_W-1:0] caddr_wr,
   input  logic [DATA_W-1:0] cdata_wr,
   input  logic              crd,
   input  logic [ADDR_W-1:0] caddr_rd,
   output logic [DATA_W-1:0] cdata_rd,
   input  logic [2:0]        csel
`ifdef CONV_MEM_STATS_EN
   ,
   output logic [12:0]       wr_cnt_l0,
   output logic [10:0]       wr_cnt_l1,
   output logic [7:0]        err_cnt
`endif
);

   localparam int unsigned     MEM_DEPTH = 1 << ADDR_W;
   localparam int unsigned     L1_AW     = (L1_DEPTH > 1) ? $clog2(L1_DEPTH) : 1;
   localparam int unsigned     CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] L1_LIM    = (ADDR_W + 1)'(L1_DEPTH);
   localparam logic [2:0]      SEL_L0    = 3'b001;
   localparam logic [2:0]      SEL_L1    = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_SERVE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;
   logic               busy_q;
   logic               hrv_q, hrv_d;
   logic [DATA_W-1:0]  hrd_q, hrd_d;

   logic [DATA_W-1:0]  img_mem [MEM_DEPTH];
   logic [DATA_W-1:0]  l0_mem  [MEM_DEPTH];
   logic [DATA_W-1:0]  l1_mem  [L1_DEPTH];

   logic               in_serve;
   logic               wr_l1_range, rd_l1_range, hd_l1_range;
   logic               img_wr_en, wr_l0_en, wr_l1_en;
   logic [DATA_W-1:0]  dump_val;

   assign in_serve    = (state_q == S_SERVE);
   assign wr_l1_range = ({1'b0, caddr_wr}  < L1_LIM);
   assign rd_l1_range = ({1'b0, caddr_rd}  < L1_LIM);
   assign hd_l1_range = ({1'b0, host_addr} < L1_LIM);
   assign img_wr_en   = (state_q == S_LOAD) && host_wr;
   assign wr_l0_en    = in_serve && cwr && (csel == SEL_L0);
   assign wr_l1_en    = in_serve && cwr && (csel == SEL_L1) && wr_l1_range;

   // Arrays are deliberately left out of reset so contents survive an abort.
   always_ff @(posedge clk) begin
      if (img_wr_en) img_mem[host_addr] <= host_data;
      if (wr_l0_en)  l0_mem[caddr_wr] <= cdata_wr;
      if (wr_l1_en)  l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
   end

   assign idata = img_mem[iaddr];

   always_comb begin
      cdata_rd = '0;
      if (crd) begin
         if (csel == SEL_L0)
            cdata_rd = l0_mem[caddr_rd];
         else if ((csel == SEL_L1) && rd_l1_range)
            cdata_rd = l1_mem[caddr_rd[L1_AW-1:0]];
      end
   end

   always_comb begin
      dump_val = '0;
      if (!host_rd_sel)
         dump_val = l0_mem[host_addr];
      else if (hd_l1_range)
         dump_val = l1_mem[host_addr[L1_AW-1:0]];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      hrv_d     = (state_q == S_DONE) && host_rd;
      hrd_d     = hrd_q;
      if (hrv_d) hrd_d = dump_val;
      case (state_q)
         S_IDLE: state_d = S_LOAD;
         S_LOAD: begin
            if (host_start) begin
               state_d = S_ARM;
               ready_d = 1'b1;
            end
         end
         S_ARM: begin
            if (busy) begin
               state_d = S_SERVE;
               cnt_d   = '0;
            end else begin
               ready_d = 1'b1;
            end
         end
         S_SERVE: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A real busy fall wins over a simultaneous timeout expiry.
            if (busy_q && !busy) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end
         S_DONE: begin
            if (host_start) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
         hrv_q     <= 1'b0;
         hrd_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         busy_q    <= busy;
         hrv_q     <= hrv_d;
         hrd_q     <= hrd_d;
      end
   end

   assign ready         = ready_q;
   assign done          = done_q;
   assign timeout       = timeout_q;
   assign host_rd_valid = hrv_q;
   assign host_rd_data  = hrd_q;

`ifdef CONV_MEM_STATS_EN
   logic [12:0] wr_cnt_l0_q, wr_cnt_l0_d;
   logic [10:0] wr_cnt_l1_q, wr_cnt_l1_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        arm_entry, bad_wr, bad_rd;
   logic [8:0]  err_sum;

   assign arm_entry = (state_d == S_ARM) && (state_q != S_ARM);
   assign bad_wr = in_serve && cwr &&
                   !((csel == SEL_L0) || ((csel == SEL_L1) && wr_l1_range));
   assign bad_rd = in_serve && crd &&
                   !((csel == SEL_L0) || ((csel == SEL_L1) && rd_l1_range));

   always_comb begin
      wr_cnt_l0_d = wr_cnt_l0_q;
      wr_cnt_l1_d = wr_cnt_l1_q;
      if (arm_entry) begin
         wr_cnt_l0_d = '0;
         wr_cnt_l1_d = '0;
      end else begin
         if (wr_l0_en) wr_cnt_l0_d = wr_cnt_l0_q + 13'd1;
         if (wr_l1_en) wr_cnt_l1_d = wr_cnt_l1_q + 11'd1;
      end
      err_sum   = {1'b0, err_cnt_q} + 9'(bad_wr) + 9'(bad_rd);
      err_cnt_d = err_sum[8] ? '1 : err_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt_l0_q <= '0;
         wr_cnt_l1_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         wr_cnt_l0_q <= wr_cnt_l0_d;
         wr_cnt_l1_q <= wr_cnt_l1_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign wr_cnt_l0 = wr_cnt_l0_q;
   assign wr_cnt_l1 = wr_cnt_l1_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_conv_mem_responder.sv
// Scoreboard bench for conv_mem_responder: a bench-side memory model predicts every read and dump.
module tb_conv_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_wr, host_start, host_rd, host_rd_sel;
   logic [11:0] host_addr;
   logic [19:0] host_data, host_rd_data;
   logic        host_rd_valid, done, timeout, ready, busy;
   logic [11:0] iaddr, caddr_wr, caddr_rd;
   logic [19:0] idata, cdata_wr, cdata_rd;
   logic        cwr, crd;
   logic [2:0]  csel;
`ifdef CONV_MEM_STATS_EN
   logic [12:0] wr_cnt_l0;
   logic [10:0] wr_cnt_l1;
   logic [7:0]  err_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [19:0] exp_q [$];
   logic [19:0] img_m [int];
   logic [19:0] l0_m [int];
   logic [19:0] l1_m [int];
   bit serving = 1'b0;
   bit loading = 1'b0;

   always #5 clk = ~clk;

   conv_mem_responder #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
      .host_start(host_start), .host_rd(host_rd), .host_rd_sel(host_rd_sel),
      .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
      .done(done), .timeout(timeout), .ready(ready), .busy(busy),
      .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
`ifdef CONV_MEM_STATS_EN
      , .wr_cnt_l0(wr_cnt_l0), .wr_cnt_l1(wr_cnt_l1), .err_cnt(err_cnt)
`endif
   );

   function automatic logic [19:0] model_rd(input logic [2:0] sel, input logic [11:0] a);
      model_rd = '0;
      if (sel == 3'b001 && l0_m.exists(int'(a)))
         model_rd = l0_m[int'(a)];
      else if (sel == 3'b011 && a < 12'd1024 && l1_m.exists(int'(a)))
         model_rd = l1_m[int'(a)];
   endfunction

   // One clock; the model commits what the bench drove at this edge.
   task automatic tick;
      @(posedge clk);
      if (loading && host_wr) img_m[int'(host_addr)] = host_data;
      if (serving && cwr) begin
         if (csel == 3'b001) l0_m[int'(caddr_wr)] = cdata_wr;
         else if (csel == 3'b011 && caddr_wr < 12'd1024) l1_m[int'(caddr_wr)] = cdata_wr;
      end
      #1;
   endtask

   task automatic push_crd(input logic [2:0] sel, input logic [11:0] a);
      crd = 1'b1; csel = sel; caddr_rd = a;
      exp_q.push_back(model_rd(sel, a));
   endtask

   task automatic push_img(input logic [11:0] a);
      iaddr = a;
      exp_q.push_back(img_m.exists(int'(a)) ? img_m[int'(a)] : 20'h0);
   endtask

   task automatic run_dump(input logic sel, input logic [11:0] a,
                           output logic ok, output logic [19:0] got, output logic [19:0] exp);
      host_rd = 1'b1; host_rd_sel = sel; host_addr = a;
      exp_q.push_back(model_rd(sel ? 3'b011 : 3'b001, a));
      tick;
      host_rd = 1'b0;
      ok = host_rd_valid;
      for (int k = 0; k < 3 && !ok; k++) begin
         tick;
         ok = host_rd_valid;
      end
      got = host_rd_data;
      exp = exp_q.pop_front();
   endtask

   task automatic test_reset;
      reset = 1'b1; host_wr = 0; host_start = 0; host_rd = 0; host_rd_sel = 0;
      host_addr = '0; host_data = '0; busy = 0; iaddr = '0; cwr = 0; crd = 0;
      caddr_wr = '0; caddr_rd = 12'd5; cdata_wr = '0; csel = 3'b001;
      tick; tick;
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", ready); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b want 0", timeout); end
      vectors++; if (host_rd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_valid: got %b want 0", host_rd_valid); end
      vectors++; if (host_rd_data !== 20'h0) begin miscompares++; $display("FAIL rst_rd_data: got %h want 0", host_rd_data); end
      vectors++; if (cdata_rd !== 20'h0) begin miscompares++; $display("FAIL rst_cdata_rd: got %h want 0", cdata_rd); end
      reset = 1'b0;
      tick;
      loading = 1'b1;
   endtask

   task automatic test_load_arm;
      logic [19:0] e;
      host_wr = 1; host_addr = 12'd0; host_data = 20'h00010;
      tick;
      host_addr = 12'd4095; host_data = 20'hFFFFF; host_start = 1;
      tick;
      loading = 0; host_wr = 0; host_start = 0;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL arm_ready: got %b want 1", ready); end
      push_img(12'd0); #1; e = exp_q.pop_front();
      vectors++; if (idata !== e) begin miscompares++; $display("FAIL idata_0: got %h want %h", idata, e); end
      push_img(12'd4095); #1; e = exp_q.pop_front();
      vectors++; if (idata !== e) begin miscompares++; $display("FAIL idata_4095: got %h want %h", idata, e); end
      tick;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL arm_ready_hold: got %b want 1", ready); end
      busy = 1; #1;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL arm_ready_busy_seen: got %b want 1", ready); end
      tick;
      serving = 1;
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL serve_ready_drop: got %b want 0", ready); end
   endtask

   task automatic test_serve_rw;
      logic [19:0] e;
      cwr = 1; csel = 3'b001; caddr_wr = 12'd5; cdata_wr = 20'h12345;
      tick;
      cwr = 0; push_crd(3'b001, 12'd5); #1; e = exp_q.pop_front();
      vectors++; if (cdata_rd !== e) begin miscompares++; $display("FAIL l0_rd_after_wr: got %h want %h", cdata_rd, e); end
      tick;
      crd = 0; cwr = 1; csel = 3'b011; caddr_wr = 12'd7; cdata_wr = 20'h00000;
      tick;
      caddr_wr = 12'd0; cdata_wr = 20'h13579;
      tick;
      caddr_wr = 12'd7; cdata_wr = 20'hAAAAA; push_crd(3'b011, 12'd7); #1; e = exp_q.pop_front();
      vectors++; if (cdata_rd !== e) begin miscompares++; $display("FAIL l1_same_cycle_old: got %h want %h", cdata_rd, e); end
      tick;
      caddr_wr = 12'd1024; cdata_wr = 20'h77777; push_crd(3'b011, 12'd7); #1; e = exp_q.pop_front();
      vectors++; if (cdata_rd !== e) begin miscompares++; $display("FAIL l1_new_visible: got %h want %h", cdata_rd, e); end
      tick;
      crd = 0; csel = 3'b010; caddr_wr = 12'd5; cdata_wr = 20'h55555;
      tick;
      cwr = 0;
`ifdef CONV_MEM_STATS_EN
      vectors++; if (err_cnt !== 8'd2) begin miscompares++; $display("FAIL err_cnt: got %0d want 2", err_cnt); end
`endif
      push_crd(3'b011, 12'd0); #1; e = exp_q.pop_front();
      vectors++; if (cdata_rd !== e) begin miscompares++; $display("FAIL l1_oob_no_alias: got %h want %h", cdata_rd, e); end
      push_crd(3'b001, 12'd5); #1; e = exp_q.pop_front();
      vectors++; if (cdata_rd !== e) begin miscompares++; $display("FAIL l0_bad_sel_no_wr: got %h want %h", cdata_rd, e); end
      push_crd(3'b010, 12'd5); #1; e = exp_q.pop_front();
      vectors++; if (cdata_rd !== e) begin miscompares++; $display("FAIL bad_sel_rd_zero: got %h want %h", cdata_rd, e); end
      push_crd(3'b011, 12'd1024); #1; e = exp_q.pop_front();
      vectors++; if (cdata_rd !== e) begin miscompares++; $display("FAIL l1_oob_rd_zero: got %h want %h", cdata_rd, e); end
      crd = 0; csel = 3'b001;
      tick;
      busy = 0; #1;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_early: got %b want 0", done); end
      tick;
      serving = 0;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL done_pulse: got %b want 1", done); end
      tick;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_one_cycle: got %b want 0", done); end
   endtask

   task automatic test_done_dump;
      logic ok; logic [19:0] got, e;
      run_dump(1'b0, 12'd5, ok, got, e);
      vectors++; if (!ok) begin miscompares++; $display("FAIL dump_l0_valid: got 0 want 1"); end
      vectors++; if (got !== e) begin miscompares++; $display("FAIL dump_l0_5: got %h want %h", got, e); end
      tick;
      vectors++; if (host_rd_valid !== 1'b0) begin miscompares++; $display("FAIL dump_valid_idle: got %b want 0", host_rd_valid); end
      run_dump(1'b1, 12'd7, ok, got, e);
      vectors++; if (!ok || got !== e) begin miscompares++; $display("FAIL dump_l1_7: got %h (valid %b) want %h", got, ok, e); end
      run_dump(1'b1, 12'd1024, ok, got, e);
      vectors++; if (!ok || got !== e) begin miscompares++; $display("FAIL dump_l1_oob: got %h (valid %b) want %h", got, ok, e); end
      host_wr = 1; host_addr = 12'd0; host_data = 20'h0BAD0;
      tick;
      host_wr = 0; push_img(12'd0); #1; e = exp_q.pop_front();
      vectors++; if (idata !== e) begin miscompares++; $display("FAIL host_wr_outside_load: got %h want %h", idata, e); end
      cwr = 1; csel = 3'b001; caddr_wr = 12'd5; cdata_wr = 20'h0;
      tick;
      cwr = 0;
      run_dump(1'b0, 12'd5, ok, got, e);
      vectors++; if (!ok || got !== e) begin miscompares++; $display("FAIL cwr_outside_serve: got %h (valid %b) want %h", got, ok, e); end
      host_start = 1;
      tick;
      host_start = 0; loading = 1;
   endtask

   task automatic test_timeout;
      logic ok; logic [19:0] got, e;
      logic done_seen;
      host_wr = 1; host_addr = 12'd1; host_data = 20'h00ABC; host_start = 1;
      tick;
      loading = 0; host_wr = 0; host_start = 0;
      busy = 1;
      tick;
      serving = 1; done_seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick;
         done_seen |= done;
      end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b want 0", timeout); end
      tick;
      serving = 0; done_seen |= done;
      vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_at_limit: got %b want 1", timeout); end
      vectors++; if (done_seen !== 1'b0) begin miscompares++; $display("FAIL timeout_no_done: got %b want 0", done_seen); end
      busy = 0;
      tick;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL busy_fall_outside_serve: got %b want 0", done); end
      vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b want 1", timeout); end
      push_img(12'd1); #1; e = exp_q.pop_front();
      vectors++; if (idata !== e) begin miscompares++; $display("FAIL idata_1: got %h want %h", idata, e); end
      run_dump(1'b1, 12'd0, ok, got, e);
      vectors++; if (!ok || got !== e) begin miscompares++; $display("FAIL dump_after_timeout: got %h (valid %b) want %h", got, ok, e); end
   endtask

   task automatic test_reset_mid_serve;
      logic ok; logic [19:0] got, e;
      host_start = 1;
      tick;
      tick;
      host_start = 0; busy = 1;
      tick;
      serving = 1;
      tick; tick; tick;
      reset = 1; busy = 0;
      tick;
      serving = 0;
      vectors++; if (ready !== 1'b0 || timeout !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL mid_reset_flags: got ready=%b timeout=%b done=%b want 0 0 0", ready, timeout, done); end
      vectors++; if (host_rd_valid !== 1'b0 || host_rd_data !== 20'h0) begin
         miscompares++; $display("FAIL mid_reset_dump_regs: got valid=%b data=%h want 0 0", host_rd_valid, host_rd_data); end
      reset = 0;
      tick;
      loading = 1;
      push_img(12'd4095); #1; e = exp_q.pop_front();
      vectors++; if (idata !== e) begin miscompares++; $display("FAIL img_persist: got %h want %h", idata, e); end
      host_wr = 1; host_addr = 12'd2; host_data = 20'h22222; host_start = 1;
      tick;
      loading = 0; host_wr = 0; host_start = 0;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rearm_ready: got %b want 1", ready); end
      push_img(12'd2); #1; e = exp_q.pop_front();
      vectors++; if (idata !== e) begin miscompares++; $display("FAIL wr_with_start: got %h want %h", idata, e); end
      busy = 1;
      tick;
      serving = 1; busy = 0;
      tick;
      serving = 0;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL done_after_reload: got %b want 1", done); end
      run_dump(1'b0, 12'd5, ok, got, e);
      vectors++; if (!ok || got !== e) begin miscompares++; $display("FAIL l0_persist: got %h (valid %b) want %h", got, ok, e); end
   endtask

   initial begin
      test_reset;
      test_load_arm;
      test_serve_rw;
      test_done_dump;
      test_timeout;
      test_reset_mid_serve;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000 ns want completion");
      $fatal(1);
   end

endmodule
